ce_timer_ctrl: RTL and testbench

Countdown timer controller built around an internal clock-enable prescaler. It owns the divider, selects the 10 Hz or 1 Hz tick period from Tmod, and sequences the IDLE/RUN/PAUSE/DONE states from start/stop/clr commands. It emits one ce_out pulse per elapsed period and flags completion after a loaded number of ticks. It sits between the front-panel button logic and the display counters.

---
 rtl/ce_timer_ctrl.sv | 93 +++++++++
 tb/tb_ce_timer_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ce_timer_ctrl.sv
// ce_timer_ctrl: countdown timer with internal clock-enable prescaler and IDLE/RUN/PAUSE/DONE sequencing
module ce_timer_ctrl #(
   parameter int F_CLK  = 50000000,
   parameter int F_FAST = 10,
   parameter int F_SLOW = 1,
   parameter int PRE_W  = 26,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             R_n,
   input  logic             start,
   input  logic             stop,
   input  logic             clr,
   input  logic             Tmod,
   input  logic [CNT_W-1:0] load_val,
   output logic             ce_out,
   output logic             done,
   output logic             busy,
   output logic [CNT_W-1:0] remaining,
   output logic [1:0]       state
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
   localparam logic [PRE_W-1:0] RLD_FAST = PRE_W'(F_CLK / F_FAST - 1);
   localparam logic [PRE_W-1:0] RLD_SLOW = PRE_W'(F_CLK / F_SLOW - 1);
   state_t             state_q;
   logic [PRE_W-1:0]   pre_q;
   logic [PRE_W-1:0]   reload_d;
   logic [CNT_W-1:0]   rem_q;
   logic               ce_q;
   logic               done_q;
   assign reload_d  = Tmod ? RLD_FAST : RLD_SLOW;
   assign ce_out    = ce_q;
   assign done      = done_q;
   assign remaining = rem_q;
   assign state     = state_q;
   assign busy      = (state_q == RUN) || (state_q == PAUSE);
   // Sequencer, prescaler and tick/done pulses; clr overrides everything including a due tick
   always_ff @(posedge clk or negedge R_n) begin
      if (!R_n) begin
         state_q <= IDLE;
         pre_q   <= '0;
         rem_q   <= '0;
         ce_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         ce_q   <= 1'b0;
         done_q <= 1'b0;
         if (clr) begin
            state_q <= IDLE;
            pre_q   <= '0;
            rem_q   <= '0;
         end else begin
            case (state_q)
               IDLE, DONE: begin
                  if (start) begin
                     if (load_val != '0) begin
                        state_q <= RUN;
                        rem_q   <= load_val;
                        pre_q   <= reload_d;
                     end else begin
                        state_q <= DONE;
                        rem_q   <= '0;
                        done_q  <= 1'b1;
                     end
                  end
               end
               RUN: begin
                  if (pre_q == '0) begin
                     ce_q  <= 1'b1;
                     pre_q <= reload_d;
                     if (rem_q <= CNT_W'(1)) begin
                        rem_q   <= '0;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (stop) state_q <= PAUSE;
                     end
                  end else if (stop) begin
                     state_q <= PAUSE;
                  end else begin
                     pre_q <= pre_q - PRE_W'(1);
                  end
               end
               PAUSE: begin
                  if (start && !stop) state_q <= RUN;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ce_timer_ctrl.sv
// tb_ce_timer_ctrl: directed checks of tick timing, pause/resume, Tmod reload, clr and async reset
module tb_ce_timer_ctrl;
   logic        clk = 1'b0;
   logic        R_n = 1'b0;
   logic        start = 1'b0, stop = 1'b0, clr = 1'b0, Tmod = 1'b1;
   logic [15:0] load_val = '0;
   logic        ce_out, done, busy;
   logic [15:0] remaining;
   logic [1:0]  state;
   int          n_chk = 0;
   int          n_fail = 0;

   ce_timer_ctrl #(.F_CLK(100), .F_FAST(10), .F_SLOW(1), .PRE_W(8), .CNT_W(16)) dut (
      .clk(clk), .R_n(R_n), .start(start), .stop(stop), .clr(clr), .Tmod(Tmod),
      .load_val(load_val), .ce_out(ce_out), .done(done), .busy(busy),
      .remaining(remaining), .state(state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic do_start(input logic [15:0] lv);
      load_val = lv;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_state", state, 0);
      chk("rst_rem", remaining, 0);
      chk("rst_ce", ce_out, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      R_n = 1'b1;
      tick();

      // 1: three fast ticks then DONE
      Tmod = 1'b1;
      do_start(16'd3);
      chk("t1_state0", state, 1);
      chk("t1_rem0", remaining, 3);
      chk("t1_busy0", busy, 1);
      for (int e = 1; e <= 30; e++) begin
         tick();
         chk("t1_ce", ce_out, (e % 10 == 0));
         chk("t1_done", done, (e == 30));
         if (e == 10) chk("t1_rem10", remaining, 2);
         if (e == 20) chk("t1_rem20", remaining, 1);
      end
      chk("t1_rem30", remaining, 0);
      chk("t1_state30", state, 3);
      tick();
      chk("t1_done_pulse", done, 0);
      chk("t1_busy_after", busy, 0);
      chk("t1_state_hold", state, 3);

      // 2: load_val=0 goes straight to DONE
      do_start(16'd0);
      chk("t2_state", state, 3);
      chk("t2_done", done, 1);
      chk("t2_ce", ce_out, 0);
      chk("t2_rem", remaining, 0);
      for (int e = 0; e < 3; e++) begin
         tick();
         chk("t2_ce_later", ce_out, 0);
         chk("t2_done_later", done, 0);
      end

      // 3: pause at edge 14, resume at edge 50
      do_clr();
      chk("t3_clr_state", state, 0);
      do_start(16'd5);
      for (int e = 1; e <= 70; e++) begin
         stop = (e == 14);
         start = (e == 50);
         tick();
         chk("t3_ce", ce_out, (e == 10 || e == 57 || e == 67));
         chk("t3_state", state, (e >= 14 && e < 50) ? 2 : 1);
         chk("t3_rem", remaining, (e < 10) ? 5 : (e < 57) ? 4 : (e < 67) ? 3 : 2);
      end
      stop = 1'b0;
      start = 1'b0;

      // 4: Tmod drops mid-period, slow period applies from the next reload
      do_clr();
      Tmod = 1'b1;
      do_start(16'd3);
      for (int e = 1; e <= 210; e++) begin
         if (e == 5) Tmod = 1'b0;
         tick();
         chk("t4_ce", ce_out, (e == 10 || e == 110 || e == 210));
         chk("t4_done", done, (e == 210));
      end
      chk("t4_state", state, 3);

      // 5a: clr on the tick edge suppresses the tick
      do_clr();
      Tmod = 1'b1;
      do_start(16'd3);
      for (int e = 1; e <= 9; e++) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t5_clr_ce", ce_out, 0);
      chk("t5_clr_state", state, 0);
      chk("t5_clr_rem", remaining, 0);
      chk("t5_clr_done", done, 0);

      // 5b: async reset while ce_out is high
      do_start(16'd3);
      for (int e = 1; e <= 10; e++) tick();
      chk("t5_pre_ce", ce_out, 1);
      chk("t5_pre_rem", remaining, 2);
      #1;
      R_n = 1'b0;
      #1;
      chk("t5_arst_ce", ce_out, 0);
      chk("t5_arst_state", state, 0);
      chk("t5_arst_rem", remaining, 0);
      chk("t5_arst_busy", busy, 0);
      chk("t5_arst_done", done, 0);
      #1;
      R_n = 1'b1;
      tick();

      // 6a: start+stop together in RUN pauses
      do_start(16'd3);
      for (int e = 1; e <= 3; e++) tick();
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      chk("t6_pause_state", state, 2);
      chk("t6_pause_busy", busy, 1);
      chk("t6_pause_rem", remaining, 3);

      // 6b: stop on the final tick edge still completes
      do_clr();
      do_start(16'd1);
      for (int e = 1; e <= 9; e++) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t6_ce", ce_out, 1);
      chk("t6_done", done, 1);
      chk("t6_state", state, 3);
      chk("t6_rem", remaining, 0);
      chk("t6_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
